// File: rtl/seq_prio_encode.sv
// seq_prio_encode: walks a 128-bit request vector, emitting each set bit's index.
// Define SEQ_PRIO_MSB_FIRST_EN for highest-index-first order.
module seq_prio_encode (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] vec_in,
  output logic         in_ready,
  output logic         valid,
  output logic [6:0]   idx,
  input  logic         out_ready,
  output logic         done,
  output logic [7:0]   count
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] pending_q, pending_d;
  logic [7:0]   count_q, count_d;
  logic         done_q, done_d;
  logic [6:0]   sel;
  logic [127:0] rest;

  // Last matching bit in scan order wins.
  always_comb begin
    sel = '0;
`ifdef SEQ_PRIO_MSB_FIRST_EN
    for (int i = 0; i < 128; i++)
      if (pending_q[i]) sel = 7'(i);
`else
    for (int i = 127; i >= 0; i--)
      if (pending_q[i]) sel = 7'(i);
`endif
  end

  assign rest = pending_q & ~(128'd1 << sel);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          pending_d = vec_in;
          count_d   = '0;
          if (|vec_in) state_d = EMIT;
          else         done_d  = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = rest;
          count_d   = count_q + 8'd1;
          if (rest == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign valid    = (state_q == EMIT);
  assign idx      = valid ? sel : 7'd0;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_seq_prio_encode.sv
// Self-checking bench for seq_prio_encode: vector table, directed
// corner sequences and random traffic against a queue-based model.
module tb_seq_prio_encode;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [127:0] vec_in;
  logic         in_ready;
  logic         valid;
  logic [6:0]   idx;
  logic         out_ready;
  logic         done;
  logic [7:0]   count;

  int errors = 0;
  int checks = 0;

  // Model: queue of indices still to be emitted, in emission order.
  int mq[$];
  int m_count;
  bit m_done;

  typedef struct {
    logic [127:0] vec;
    int first;
    int last;
    int n;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  seq_prio_encode dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .vec_in(vec_in),
    .in_ready(in_ready),
    .valid(valid),
    .idx(idx),
    .out_ready(out_ready),
    .done(done),
    .count(count)
  );

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_load(logic [127:0] v);
    mq.delete();
    for (int i = 0; i < 128; i++)
      if (v[i]) mq.push_back(i);
`ifdef SEQ_PRIO_MSB_FIRST_EN
    mq.reverse();
`endif
    m_count = 0;
    m_done  = (v == '0);
  endfunction

  task automatic check_all(string tag);
    bit busy;
    busy = (mq.size() > 0);
    chk({tag, ".valid"}, 128'(valid), 128'(busy));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(!busy));
    chk({tag, ".idx"}, 128'(idx), busy ? 128'(mq[0]) : 128'd0);
    chk({tag, ".count"}, 128'(count), 128'(m_count));
    chk({tag, ".done"}, 128'(done), 128'(m_done));
  endtask

  // Called at a negedge: drive, clock, advance model, check at next negedge.
  task automatic step(bit ld, logic [127:0] v, bit ordy, string tag);
    bit idle;
    load      = ld;
    vec_in    = v;
    out_ready = ordy;
    idle      = (mq.size() == 0);
    @(posedge clk);
    if (idle && ld) begin
      model_load(v);
    end else if (!idle && ordy) begin
      void'(mq.pop_front());
      m_count++;
      m_done = (mq.size() == 0);
    end else begin
      m_done = 1'b0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    mq.delete();
    m_count = 0;
    m_done  = 1'b0;
    check_all(tag);
    @(negedge clk);
    check_all(tag);
    rst = 1'b0;
  endtask

  initial begin
    int first, last, k;
    logic [127:0] v;
    logic [127:0] exp_hold;

    tbl[0] = '{128'h8000_0000_0000_0000_0000_0000_0000_0005, 0, 127, 3};
    tbl[1] = '{128'h0, -1, -1, 0};
    tbl[2] = '{{128{1'b1}}, 0, 127, 128};
    tbl[3] = '{128'h30, 4, 5, 2};
    tbl[4] = '{128'h1, 0, 0, 1};
    tbl[5] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 127, 127, 1};
    tbl[6] = '{128'hF0, 4, 7, 4};
    tbl[7] = '{128'h0, -1, -1, 0};

    load = 1'b0;
    vec_in = '0;
    out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    do_reset("reset");

    // Back-to-back table entries also load in the done cycle.
    for (int t = 0; t < 8; t++) begin
      int ef, el;
      ef = tbl[t].first;
      el = tbl[t].last;
`ifdef SEQ_PRIO_MSB_FIRST_EN
      ef = tbl[t].last;
      el = tbl[t].first;
`endif
      step(1'b1, tbl[t].vec, 1'b1, "tbl_load");
      first = -1;
      last = -1;
      k = 0;
      while (!done && k < 200) begin
        if (valid) begin
          if (first < 0) first = int'(idx);
          last = int'(idx);
        end
        step(1'b0, '0, 1'b1, "tbl_run");
        k++;
      end
      chk($sformatf("tbl%0d.first", t), 128'(first), 128'(ef));
      chk($sformatf("tbl%0d.last", t), 128'(last), 128'(el));
      chk($sformatf("tbl%0d.count", t), 128'(count), 128'(tbl[t].n));
      chk($sformatf("tbl%0d.cycles", t), 128'(k), 128'(tbl[t].n));
    end
    @(negedge clk);
    step(1'b0, '0, 1'b0, "idle");

    // Stall: index must hold while loads during EMIT are ignored.
`ifdef SEQ_PRIO_MSB_FIRST_EN
    exp_hold = 128'd5;
`else
    exp_hold = 128'd4;
`endif
    step(1'b1, 128'h30, 1'b0, "stall_load");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 128'hFFFF_0000, 1'b0, "stall");
      chk("stall.idx", 128'(idx), exp_hold);
      chk("stall.valid", 128'(valid), 128'd1);
    end
    step(1'b0, '0, 1'b1, "stall_rel1");
    step(1'b0, '0, 1'b1, "stall_rel2");
    chk("stall.done", 128'(done), 128'd1);
    chk("stall.count", 128'(count), 128'd2);

    // Reset in EMIT: no done, then a fresh load works.
    step(1'b1, 128'hF0, 1'b1, "rst_load");
    step(1'b0, '0, 1'b1, "rst_acc");
    do_reset("rst_mid");
    step(1'b0, '0, 1'b1, "rst_after");
    chk("rst_after.done", 128'(done), 128'd0);
    step(1'b1, 128'h1, 1'b1, "rst_reload");
    chk("rst_reload.idx", 128'(idx), 128'd0);
    step(1'b0, '0, 1'b1, "rst_drain");
    chk("rst_drain.done", 128'(done), 128'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: v = '0;
        1: v = v & {$urandom, $urandom, $urandom, $urandom}
                 & {$urandom, $urandom, $urandom, $urandom}
                 & {$urandom, $urandom, $urandom, $urandom};
        2: v = 128'(1) << $urandom_range(0, 127);
        default: v = v & {$urandom, $urandom, $urandom, $urandom}
                        & {$urandom, $urandom, $urandom, $urandom};
      endcase
      step(($urandom_range(0, 3) == 0), v, ($urandom_range(0, 2) != 0),
           "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_prio_encode.md
SEQ_PRIO_ENCODE -- requirements
Module: seq_prio_encode

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset; ports, clock and reset first:
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 load  input  1  capture vec_in when in_ready=1.
REQ-005 vec_in  input  128  request vector; bit n stands for index n.
REQ-006 in_ready  output  1  high in IDLE only.
REQ-007 valid  output  1  idx is presented.
REQ-008 idx  output  7  index of the selected set bit of the pending vector.
REQ-009 out_ready  input  1  consumer accepts idx when valid=1.
REQ-010 done  output  1  one-cycle pulse when a loaded vector is fully drained.
REQ-011 count  output  8  indices accepted since the last load, 0..128.

Function
REQ-012 The block SHALL be the inverse of the team's 7-to-128 one-hot decoder: it walks a 128-bit vector and emits each set bit's 7-bit index, one per handshake.
REQ-013 States SHALL be IDLE and EMIT, held in a registered `pending[127:0]` plus the state register.
REQ-014 IDLE: in_ready=1, valid=0; on load=1 SHALL set pending<=vec_in and count<=0.
REQ-015 On load with vec_in nonzero, the next state SHALL be EMIT.
REQ-016 On load with vec_in=0, the block SHALL stay in IDLE and pulse done in the next cycle.
REQ-017 EMIT: valid=1, in_ready=0, and idx SHALL be driven combinationally from pending; valid SHALL rise the cycle after load.
REQ-018 Default selection SHALL be lowest-index-first: idx is the lowest set bit of pending.
REQ-019 On valid && out_ready, the block SHALL clear pending[idx] and increment count.
REQ-020 If that accepted bit was the last set bit, the state SHALL go to IDLE and done SHALL be 1 in the following cycle only.
REQ-021 With out_ready=0, idx and pending SHALL hold stable; valid SHALL never drop without acceptance.
REQ-022 load while in_ready=0 SHALL be ignored, with no effect on pending or count.
REQ-023 A new load SHALL be accepted in the cycle done is high, since the state is already IDLE.
REQ-024 The maximum count SHALL be 128 (vec_in all ones); count SHALL not wrap.
REQ-025 Throughput SHALL be one index per cycle with out_ready held high.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, pending=0, count=0, valid=0, done=0, idx=0, in_ready=1.
REQ-027 A reset during EMIT SHALL discard remaining bits and SHALL NOT pulse done.

Configuration
REQ-028 When macro SEQ_PRIO_MSB_FIRST_EN is defined, idx SHALL select the highest set bit of pending (descending order).
REQ-029 When SEQ_PRIO_MSB_FIRST_EN is undefined, selection SHALL be lowest-first; all other behaviour SHALL be identical.

Verification
REQ-030 Load vec_in=128'h8000_0000_0000_0000_0000_0000_0000_0005, out_ready=1 -> idx 0,2,127 on 3 consecutive cycles; done pulses next cycle; count=3.
REQ-031 Load vec_in=0 -> no valid; done=1 exactly one cycle later; count=0.
REQ-032 Load all ones, out_ready=1 -> idx 0..127 in order over 128 cycles; count=128; then done.
REQ-033 Load 128'h30, hold out_ready=0 for 5 cycles -> idx=4 stable with valid=1 throughout; release -> idx 4 then 5; load pulses during EMIT are ignored.
REQ-034 Load 128'hF0 and accept one index, then assert rst -> all outputs at reset values, no done; the next load of 128'h1 yields idx=0.
REQ-035 With SEQ_PRIO_MSB_FIRST_EN defined, load 128'h8000_0000_0000_0000_0000_0000_0000_0005 -> idx 127,2,0.
